pkt_bus_arbiter: RTL

- Round-robin arbiter that shares the single burst memory port (read channel for packet IN, write channel for packet OUT) between NUM_MASTERS packet-processing requesters.
- Grants one requester at a time and locks the grant until that requester's burst fully completes.
- Drives the select for an external channel mux in the top level and observes the muxed bus handshakes to detect burst start and end.
- Includes an address-phase watchdog so that an idle grantee cannot stall the port.

---
 rtl/pkt_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/pkt_bus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet-path bus arbiters.
package pkt_arb_pkg;

  // Arbiter FSM: wait for a request, wait for the address handshake,
  // then follow the read or write burst to completion.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } arb_state_e;

  // Default number of cycles a grantee may take to issue its address.
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage : pkt_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from ptr_i+1, wrapping at N. The entry at ptr_i has the lowest priority.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] pick_idx_o
);

  int cand;

  // Scan the N candidates in priority order and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    valid_o    = 1'b0;
    pick_o     = '0;
    pick_idx_o = '0;
    cand       = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o      = 1'b1;
        pick_o[cand] = 1'b1;
        pick_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/pkt_bus_arbiter.sv
// Round-robin arbiter for the shared burst memory port. The grant is held
// from selection until the owner's burst completes; an address-phase
// watchdog revokes a grantee that never issues its address.
module pkt_bus_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int IDX_W          = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] req_wr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   busy,
  output logic [NUM_MASTERS-1:0] done,
  output logic                   timeout_err,
  input  logic                   arvalid,
  input  logic                   arready,
  input  logic                   awvalid,
  input  logic                   awready,
  input  logic                   rvalid,
  input  logic                   rready,
  input  logic                   rlast,
  input  logic                   wvalid,
  input  logic                   wready,
  input  logic                   wlast,
  input  logic                   bvalid,
  input  logic                   bready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic                   cur_wr_q, cur_wr_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic [NUM_MASTERS-1:0] done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;

  logic arnext, awnext, rnext, wnext, bnext;
  assign arnext = arvalid && arready;
  assign awnext = awvalid && awready;
  assign rnext  = rvalid  && rready;
  assign wnext  = wvalid  && wready;
  assign bnext  = bvalid  && bready;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req),
    .ptr_i      (rr_ptr_q),
    .valid_o    (pick_valid),
    .pick_o     (pick_oh),
    .pick_idx_o (pick_idx)
  );

  // Next-state, grant bookkeeping and one-cycle status pulses.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    cur_wr_d  = cur_wr_q;
    rr_ptr_d  = rr_ptr_q;
    wd_cnt_d  = wd_cnt_q;
    done_d    = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ADDR;
          gnt_d     = pick_oh;
          gnt_idx_d = pick_idx;
          cur_wr_d  = req_wr[pick_idx];
          wd_cnt_d  = '0;
        end
      end
      ADDR: begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
        // Address handshake beats both withdrawal and watchdog expiry.
        if (!cur_wr_q && arnext) begin
          state_d = RD_DATA;
        end else if (cur_wr_q && awnext) begin
          state_d = WR_DATA;
        end else if (!req[gnt_idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Revoked master drops to lowest priority.
          state_d   = IDLE;
          gnt_d     = '0;
          timeout_d = 1'b1;
          rr_ptr_d  = gnt_idx_q;
        end
      end
      RD_DATA: begin
        if (rnext && rlast) begin
          state_d  = IDLE;
          gnt_d    = '0;
          done_d   = gnt_q;
          rr_ptr_d = gnt_idx_q;
        end
      end
      WR_DATA: begin
        if (wnext && wlast) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bnext) begin
          state_d  = IDLE;
          gnt_d    = '0;
          done_d   = gnt_q;
          rr_ptr_d = gnt_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and grant registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      cur_wr_q  <= 1'b0;
      rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt_q  <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      cur_wr_q  <= cur_wr_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule : pkt_bus_arbiter
